// File: rtl/axis_bus_serializer_pkg.sv
// Shared types and helpers for the bus-snapshot to AXI4-Stream serializer.
package axis_bus_serializer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Beat index width; a single-beat packet still needs a 1-bit index.
    function automatic int calc_idx_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/axis_bus_serializer_if.sv
// Snapshot handshake plus AXI4-Stream master signals of the serializer.
interface axis_bus_serializer_if #(
    parameter int C_DATA_WIDTH = 128,
    parameter int WORDS_NUM    = 16
) ();
    localparam int BUS_WIDTH = C_DATA_WIDTH * WORDS_NUM;

    logic                      bus_valid;
    logic                      bus_ready;
    logic [BUS_WIDTH-1:0]      bus_data;
    logic                      m_axis_tvalid;
    logic                      m_axis_tready;
    logic [C_DATA_WIDTH-1:0]   m_axis_tdata;
    logic [C_DATA_WIDTH/8-1:0] m_axis_tkeep;
    logic                      m_axis_tlast;

    modport master (
        input  bus_valid, bus_data, m_axis_tready,
        output bus_ready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
    );

    modport slave (
        output bus_valid, bus_data, m_axis_tready,
        input  bus_ready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
    );
endinterface

// File: rtl/axis_bus_serializer.sv
// Captures one wide bus snapshot and streams it out as a WORDS_NUM-beat
// AXI4-Stream packet, least-significant slice first, tlast on the final beat.
module axis_bus_serializer
    import axis_bus_serializer_pkg::*;
#(
    parameter int C_DATA_WIDTH = 128,
    parameter int WORDS_NUM    = 16
) (
    input  logic                  m_axis_aclk,
    input  logic                  m_axis_aresetn,
    axis_bus_serializer_if.master sio,
    output logic                  busy,
    output logic [31:0]           pkt_cnt
);
    localparam int BUS_WIDTH = C_DATA_WIDTH * WORDS_NUM;
    localparam int IDX_W     = calc_idx_w(WORDS_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_NUM - 1);

    state_t                                 state_q, state_d;
    logic [IDX_W-1:0]                       word_idx_q, word_idx_d;
    logic [WORDS_NUM-1:0][C_DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [31:0]                            pkt_cnt_q, pkt_cnt_d;

    logic                    tvalid;
    logic                    tlast;
    logic                    beat_hs;
    logic                    last_hs;
    logic                    ready;
    logic                    capture;
    logic [C_DATA_WIDTH-1:0] beat_word;

    if (WORDS_NUM == 1) begin : g_single
        assign beat_word = shadow_q[0];
    end else begin : g_multi
        assign beat_word = shadow_q[word_idx_q];
    end

    assign tvalid  = (state_q == SEND);
    assign tlast   = tvalid && (word_idx_q == LAST_IDX);
    assign beat_hs = tvalid && sio.m_axis_tready;
    assign last_hs = beat_hs && tlast;
    // Ready during the final beat lets the next snapshot follow with no bubble.
    assign ready   = (state_q == IDLE) || last_hs;
    assign capture = sio.bus_valid && ready;

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        shadow_d   = shadow_q;
        pkt_cnt_d  = pkt_cnt_q;

        if (last_hs) begin
            pkt_cnt_d  = pkt_cnt_q + 32'd1;
            word_idx_d = '0;
            state_d    = IDLE;
        end else if (beat_hs) begin
            word_idx_d = word_idx_q + IDX_W'(1);
        end

        if (capture) begin
            shadow_d   = sio.bus_data;
            word_idx_d = '0;
            state_d    = SEND;
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            shadow_q   <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            shadow_q   <= shadow_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign sio.bus_ready     = ready;
    assign sio.m_axis_tvalid = tvalid;
    assign sio.m_axis_tdata  = beat_word;
    assign sio.m_axis_tkeep  = '1;
    assign sio.m_axis_tlast  = tlast;
    assign busy              = tvalid;
    assign pkt_cnt           = pkt_cnt_q;

endmodule

// File: tb/tb_axis_bus_serializer.sv
// Scoreboard bench for axis_bus_serializer: a 4x32 instance and a 1x32 instance.
module tb_axis_bus_serializer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axis_bus_serializer_if #(.C_DATA_WIDTH(32), .WORDS_NUM(4)) v4 ();
    axis_bus_serializer_if #(.C_DATA_WIDTH(32), .WORDS_NUM(1)) v1 ();

    logic        busy4, busy1;
    logic [31:0] cnt4, cnt1;

    axis_bus_serializer #(.C_DATA_WIDTH(32), .WORDS_NUM(4)) dut4 (
        .m_axis_aclk(clk), .m_axis_aresetn(rst_n), .sio(v4), .busy(busy4), .pkt_cnt(cnt4)
    );
    axis_bus_serializer #(.C_DATA_WIDTH(32), .WORDS_NUM(1)) dut1 (
        .m_axis_aclk(clk), .m_axis_aresetn(rst_n), .sio(v1), .busy(busy1), .pkt_cnt(cnt1)
    );

    int n_pass  = 0;
    int n_total = 0;
    int beats4  = 0;
    int beats1  = 0;
    logic [32:0] q4[$];
    logic [32:0] q1[$];
    logic [32:0] e4, e1;

    // Output monitors: pop the expected {tlast,tdata} on every accepted beat.
    always @(negedge clk) begin
        if (v4.m_axis_tvalid && v4.m_axis_tready) begin
            beats4++;
            n_total++;
            if (q4.size() == 0) begin
                $display("FAIL beat4_unexpected: got last=%b data=%h, want no beat", v4.m_axis_tlast, v4.m_axis_tdata);
            end else begin
                e4 = q4.pop_front();
                if ({v4.m_axis_tlast, v4.m_axis_tdata} !== e4)
                    $display("FAIL beat4: got last=%b data=%h, want last=%b data=%h",
                             v4.m_axis_tlast, v4.m_axis_tdata, e4[32], e4[31:0]);
                else n_pass++;
            end
        end
        if (v1.m_axis_tvalid && v1.m_axis_tready) begin
            beats1++;
            n_total++;
            if (q1.size() == 0) begin
                $display("FAIL beat1_unexpected: got last=%b data=%h, want no beat", v1.m_axis_tlast, v1.m_axis_tdata);
            end else begin
                e1 = q1.pop_front();
                if ({v1.m_axis_tlast, v1.m_axis_tdata} !== e1)
                    $display("FAIL beat1: got last=%b data=%h, want last=%b data=%h",
                             v1.m_axis_tlast, v1.m_axis_tdata, e1[32], e1[31:0]);
                else n_pass++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [127:0] d, input int nbeats);
        for (int i = 0; i < nbeats; i++) q4.push_back({(i == 3), d[i*32 +: 32]});
    endtask

    task automatic start4(input logic [127:0] d);
        push4(d, 4);
        v4.bus_data  = d;
        v4.bus_valid = 1'b1;
        tick();
        v4.bus_valid = 1'b0;
    endtask

    task automatic drain4(output int cyc);
        cyc = 0;
        while (v4.m_axis_tvalid && cyc < 50) begin
            cyc++;
            tick();
        end
    endtask

    task automatic test_reset();
        #1;
        n_total++; if (v4.m_axis_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", v4.m_axis_tvalid); else n_pass++;
        n_total++; if (v4.m_axis_tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", v4.m_axis_tlast); else n_pass++;
        n_total++; if (v4.m_axis_tdata !== 32'h0) $display("FAIL rst_tdata: got %h want 0", v4.m_axis_tdata); else n_pass++;
        n_total++; if (v4.m_axis_tkeep !== 4'hF) $display("FAIL rst_tkeep: got %h want f", v4.m_axis_tkeep); else n_pass++;
        n_total++; if (busy4 !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy4); else n_pass++;
        n_total++; if (cnt4 !== 32'h0) $display("FAIL rst_cnt: got %h want 0", cnt4); else n_pass++;
        n_total++; if (v4.bus_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", v4.bus_ready); else n_pass++;
        n_total++; if (v1.m_axis_tlast !== 1'b0) $display("FAIL rst_tlast1: got %b want 0", v1.m_axis_tlast); else n_pass++;
        n_total++; if (v1.bus_ready !== 1'b1) $display("FAIL rst_ready1: got %b want 1", v1.bus_ready); else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int b0;
        b0 = beats4;
        start4(128'h44444444_33333333_22222222_11111111);
        n_total++; if (v4.m_axis_tvalid !== 1'b1) $display("FAIL single_latency: got tvalid=%b want 1", v4.m_axis_tvalid); else n_pass++;
        n_total++; if (v4.m_axis_tdata !== 32'h11111111) $display("FAIL single_beat0: got %h want 11111111", v4.m_axis_tdata); else n_pass++;
        n_total++; if (v4.m_axis_tlast !== 1'b0) $display("FAIL single_last0: got %b want 0", v4.m_axis_tlast); else n_pass++;
        tick(); tick(); tick();
        n_total++; if (v4.m_axis_tlast !== 1'b1) $display("FAIL single_last3: got %b want 1", v4.m_axis_tlast); else n_pass++;
        tick();
        n_total++; if (busy4 !== 1'b0) $display("FAIL single_busy: got %b want 0", busy4); else n_pass++;
        n_total++; if (cnt4 !== 32'd1) $display("FAIL single_cnt: got %0d want 1", cnt4); else n_pass++;
        n_total++; if (beats4 - b0 !== 4) $display("FAIL single_beats: got %0d want 4", beats4 - b0); else n_pass++;
    endtask

    task automatic test_backpressure();
        int b0, cyc, hs, stall;
        b0 = beats4; cyc = 0; hs = 0; stall = 0;
        start4(128'h44444444_33333333_22222222_11111111);
        v4.bus_data = 128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE;
        while (v4.m_axis_tvalid && cyc < 50) begin
            if (hs == 2 && stall < 3) begin
                v4.m_axis_tready = 1'b0;
                stall++;
                n_total++;
                if ({v4.m_axis_tlast, v4.m_axis_tdata} !== {1'b0, 32'h33333333})
                    $display("FAIL bp_hold: got last=%b data=%h want last=0 data=33333333", v4.m_axis_tlast, v4.m_axis_tdata);
                else n_pass++;
            end else begin
                v4.m_axis_tready = 1'b1;
            end
            if (v4.m_axis_tvalid && v4.m_axis_tready) hs++;
            cyc++;
            tick();
        end
        v4.m_axis_tready = 1'b1;
        n_total++; if (cyc !== 7) $display("FAIL bp_cycles: got %0d want 7", cyc); else n_pass++;
        n_total++; if (beats4 - b0 !== 4) $display("FAIL bp_beats: got %0d want 4", beats4 - b0); else n_pass++;
        n_total++; if (cnt4 !== 32'd2) $display("FAIL bp_cnt: got %0d want 2", cnt4); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc, rdy;
        logic took;
        cyc = 0; rdy = 0;
        push4(128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1, 4);
        push4(128'hB4B4B4B4_B3B3B3B3_B2B2B2B2_B1B1B1B1, 4);
        v4.bus_data  = 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1;
        v4.bus_valid = 1'b1;
        tick();
        v4.bus_data = 128'hB4B4B4B4_B3B3B3B3_B2B2B2B2_B1B1B1B1;
        while (v4.m_axis_tvalid && cyc < 50) begin
            took = v4.bus_ready && v4.bus_valid;
            if (v4.bus_ready) begin
                rdy++;
                n_total++; if (v4.m_axis_tlast !== 1'b1) $display("FAIL b2b_ready_on_last: got tlast=%b want 1", v4.m_axis_tlast); else n_pass++;
            end
            cyc++;
            tick();
            if (took) v4.bus_valid = 1'b0;
        end
        v4.bus_valid = 1'b0;
        n_total++; if (cyc !== 8) $display("FAIL b2b_cycles: got %0d want 8", cyc); else n_pass++;
        n_total++; if (rdy !== 2) $display("FAIL b2b_ready_pulses: got %0d want 2", rdy); else n_pass++;
        n_total++; if (cnt4 !== 32'd4) $display("FAIL b2b_cnt: got %0d want 4", cnt4); else n_pass++;
    endtask

    task automatic test_words1();
        logic [31:0] vals [3];
        int b0;
        vals[0] = 32'hC0C0C0C0; vals[1] = 32'hC1C1C1C1; vals[2] = 32'hC2C2C2C2;
        b0 = beats1;
        v1.bus_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            v1.bus_data = vals[k];
            q1.push_back({1'b1, vals[k]});
            n_total++; if (v1.bus_ready !== 1'b1) $display("FAIL w1_ready%0d: got %b want 1", k, v1.bus_ready); else n_pass++;
            tick();
            n_total++; if (v1.m_axis_tlast !== 1'b1) $display("FAIL w1_tlast%0d: got %b want 1", k, v1.m_axis_tlast); else n_pass++;
        end
        v1.bus_valid = 1'b0;
        tick();
        n_total++; if (cnt1 !== 32'd3) $display("FAIL w1_cnt: got %0d want 3", cnt1); else n_pass++;
        n_total++; if (beats1 - b0 !== 3) $display("FAIL w1_beats: got %0d want 3", beats1 - b0); else n_pass++;
        n_total++; if (busy1 !== 1'b0) $display("FAIL w1_busy: got %b want 0", busy1); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        push4(128'h54545454_53535353_52525252_51515151, 2);
        v4.bus_data  = 128'h54545454_53535353_52525252_51515151;
        v4.bus_valid = 1'b1;
        tick();
        v4.bus_valid = 1'b0;
        tick(); tick();
        n_total++; if (v4.m_axis_tdata !== 32'h53535353) $display("FAIL rm_pre: got %h want 53535353", v4.m_axis_tdata); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (v4.m_axis_tvalid !== 1'b0) $display("FAIL rm_tvalid: got %b want 0", v4.m_axis_tvalid); else n_pass++;
        n_total++; if (v4.m_axis_tlast !== 1'b0) $display("FAIL rm_tlast: got %b want 0", v4.m_axis_tlast); else n_pass++;
        n_total++; if (cnt4 !== 32'd0) $display("FAIL rm_cnt: got %0d want 0", cnt4); else n_pass++;
        n_total++; if (v4.bus_ready !== 1'b1) $display("FAIL rm_ready: got %b want 1", v4.bus_ready); else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        start4({4{32'hAAAAAAAA}});
        n_total++; if (v4.m_axis_tdata !== 32'hAAAAAAAA) $display("FAIL rm_beat0: got %h want aaaaaaaa", v4.m_axis_tdata); else n_pass++;
        drain4(cyc);
        n_total++; if (cyc !== 4) $display("FAIL rm_cycles: got %0d want 4", cyc); else n_pass++;
        n_total++; if (cnt4 !== 32'd1) $display("FAIL rm_cnt_after: got %0d want 1", cnt4); else n_pass++;
    endtask

    task automatic test_wrap();
        int cyc;
        force dut4.pkt_cnt_d = 32'hFFFF_FFFF;
        tick();
        release dut4.pkt_cnt_d;
        #1;
        n_total++; if (cnt4 !== 32'hFFFF_FFFF) $display("FAIL wrap_preload: got %h want ffffffff", cnt4); else n_pass++;
        start4(128'h64646464_63636363_62626262_61616161);
        drain4(cyc);
        n_total++; if (cyc !== 4) $display("FAIL wrap_cycles: got %0d want 4", cyc); else n_pass++;
        n_total++; if (cnt4 !== 32'h0) $display("FAIL wrap_cnt: got %h want 0", cnt4); else n_pass++;
    endtask

    initial begin
        rst_n            = 1'b0;
        v4.bus_valid     = 1'b0;
        v4.bus_data      = '0;
        v4.m_axis_tready = 1'b1;
        v1.bus_valid     = 1'b0;
        v1.bus_data      = '0;
        v1.m_axis_tready = 1'b1;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_words1();
        test_reset_mid();
        test_wrap();
        tick();
        n_total++; if (q4.size() != 0) $display("FAIL sb4_leftover: got %0d beats want 0", q4.size()); else n_pass++;
        n_total++; if (q1.size() != 0) $display("FAIL sb1_leftover: got %0d beats want 0", q1.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
